// File: rtl/sb_serializer.sv
// ---------------------------------------------------------------------------
// sb_serializer
//
// Sideband transmit serializer. A WIDTH-bit word is taken over a valid/ready
// handshake and shifted out LSB first, one bit per clk. out_clk_en gates the
// forwarded sideband clock so the link partner sees exactly WIDTH edges per
// word. Data changes on posedge clk; the receiver samples on negedge.
//
// Optional feature macro: SB_SER_GAP_EN
//   defined   : GAP idle cycles (data 0, clock gated) follow every word.
//   undefined : the serializer returns to IDLE straight after the last bit.
//
// Ports:
//   clk        in   TX clock, all state on posedge
//   rst        in   asynchronous active-high reset
//   in_data    in   parallel word, bit 0 sent first
//   in_valid   in   in_data is valid
//   in_ready   out  serializer can accept a word (state is IDLE)
//   out_data   out  registered serial data to the pad
//   out_clk_en out  registered forwarded-clock enable, high only with data
//   busy       out  state is not IDLE
// ---------------------------------------------------------------------------
module sb_serializer #(
    parameter int WIDTH   = 128,
    parameter int GAP     = 32,
    parameter int WIDTH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_data,
    output logic             out_clk_en,
    output logic             busy
);

    // Reject configurations the counters cannot represent.
    if (WIDTH < 2 || GAP < 1) begin : g_param_check
        $error("sb_serializer: WIDTH must be >= 2 and GAP must be >= 1");
    end

`ifdef SB_SER_GAP_EN
    localparam int GAP_W = $clog2(GAP + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    logic [GAP_W-1:0] gapcnt_q;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1
    } state_t;
`endif

    localparam logic [WIDTH_W-1:0] BIT_LAST = WIDTH_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [WIDTH_W-1:0] bitcnt_q;
    logic               out_data_q;
    logic               out_clk_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            out_data_q   <= 1'b0;
            out_clk_en_q <= 1'b0;
`ifdef SB_SER_GAP_EN
            gapcnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Bit 0 goes out on the accept edge itself, so the shift
                    // register only needs to hold the remaining bits.
                    if (in_valid) begin
                        shreg_q      <= in_data >> 1;
                        out_data_q   <= in_data[0];
                        out_clk_en_q <= 1'b1;
                        bitcnt_q     <= '0;
                        state_q      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // bitcnt tracks which bit is currently on the line.
                    if (bitcnt_q != BIT_LAST) begin
                        out_data_q <= shreg_q[0];
                        shreg_q    <= shreg_q >> 1;
                        bitcnt_q   <= bitcnt_q + 1'b1;
                    end else begin
                        out_data_q   <= 1'b0;
                        out_clk_en_q <= 1'b0;
                        bitcnt_q     <= '0;
`ifdef SB_SER_GAP_EN
                        gapcnt_q     <= '0;
                        state_q      <= ST_GAP;
`else
                        state_q      <= ST_IDLE;
`endif
                    end
                end
`ifdef SB_SER_GAP_EN
                ST_GAP: begin
                    if (gapcnt_q == GAP_LAST) begin
                        gapcnt_q <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        gapcnt_q <= gapcnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_q      <= ST_IDLE;
                    out_data_q   <= 1'b0;
                    out_clk_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready depends on state only, never on in_valid.
    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_data   = out_data_q;
    assign out_clk_en = out_clk_en_q;

endmodule

// File: tb/tb_sb_serializer.sv
module tb_sb_serializer;

    localparam int W  = 128;
    localparam int G  = 32;
    localparam int SW = 8;
    localparam int SG = 4;
`ifdef SB_SER_GAP_EN
    localparam int GAP_CYC  = G;
    localparam int SGAP_CYC = SG;
`else
    localparam int GAP_CYC  = 0;
    localparam int SGAP_CYC = 0;
`endif

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          out_data;
    logic          out_clk_en;
    logic          busy;

    logic [SW-1:0] s_in_data;
    logic          s_in_valid;
    logic          s_in_ready;
    logic          s_out_data;
    logic          s_out_clk_en;
    logic          s_busy;

    bit exp_q[$];
    bit sexp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    sb_serializer #(.WIDTH(W), .GAP(G)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_clk_en(out_clk_en),
        .busy(busy)
    );

    sb_serializer #(.WIDTH(SW), .GAP(SG)) u_small (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .out_data(s_out_data), .out_clk_en(s_out_clk_en),
        .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) exp_q.push_back(w[i]);
    endtask

    task automatic push_small(input logic [SW-1:0] w);
        for (int i = 0; i < SW; i++) sexp_q.push_back(w[i]);
    endtask

    task automatic test_reset;
        rst = 1'b0; in_data = '0; in_valid = 1'b0; s_in_data = '0; s_in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_data, out_clk_en, busy, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_main: data/en/busy/ready=%b required 0001",
                     {out_data, out_clk_en, busy, in_ready});
        end
        n_checks++;
        if ({s_out_data, s_out_clk_en, s_busy, s_in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_small: data/en/busy/ready=%b required 0001",
                     {s_out_data, s_out_clk_en, s_busy, s_in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_idle;
        int bad = 0;
        in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_data, out_clk_en, in_ready} !== 3'b001) begin
                n_fail++; bad++;
                if (bad < 5)
                    $display("FAIL idle cycle %0d: data/en/ready=%b required 001",
                             c, {out_data, out_clk_en, in_ready});
            end
        end
    endtask

    task automatic test_single_word;
        logic [W-1:0] word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        logic [W-1:0] rebuilt = '0;
        bit e;
        int n;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_ready: in_ready=%b required 1", in_ready);
        end
        in_data = word; in_valid = 1'b1; push_word(word);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            e = exp_q.size() ? exp_q.pop_front() : 1'b0;
            n_checks++;
            if (out_clk_en !== 1'b1 || out_data !== e) begin
                n_fail++;
                $display("FAIL single_bit %0d: en=%b data=%b required en=1 data=%b",
                         k, out_clk_en, out_data, e);
            end
            rebuilt[k] = out_data;
        end
        n_checks++;
        if (rebuilt !== word) begin
            n_fail++; $display("FAIL single_rebuild: got %h required %h", rebuilt, word);
        end
        @(negedge clk);
        n = 0;
        while (!in_ready && n < GAP_CYC + 4) begin
            n_checks++;
            if ({out_data, out_clk_en, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL single_gap cycle %0d: data/en/busy=%b required 001",
                         n, {out_data, out_clk_en, busy});
            end
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != GAP_CYC || {out_data, out_clk_en, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_tail: idle after %0d cycles data/en/busy=%b required %0d cycles 000",
                     n, {out_data, out_clk_en, busy}, GAP_CYC);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] wa = {$urandom, $urandom, $urandom, $urandom};
        logic [W-1:0] wb = {$urandom, $urandom, $urandom, $urandom};
        int acc_cyc[2] = '{0, 0};
        int n_acc = 0;
        int chg = 0;
        bit e;
        @(negedge clk);
        in_data = wa; in_valid = 1'b1;
        for (int cyc = 0; cyc < 2 * (W + GAP_CYC + 1) + 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (chg == 1) in_data = wb;
            if (chg == 2) in_valid = 1'b0;
            chg = 0;
            if (out_clk_en === 1'b1) begin
                e = exp_q.size() ? exp_q.pop_front() : 1'b0;
                n_checks++;
                if (out_data !== e || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_bit cyc %0d: data=%b ready=%b required data=%b ready=0",
                             cyc, out_data, in_ready, e);
                end
            end else begin
                n_checks++;
                if (out_data !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_quiet cyc %0d: data=%b required 0", cyc, out_data);
                end
            end
            if (in_valid && in_ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc; n_acc++; push_word(in_data); chg = n_acc;
            end
            if (n_acc == 2 && exp_q.size() == 0 && out_clk_en !== 1'b1 && chg == 0) break;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_acc != 2 || acc_cyc[1] - acc_cyc[0] != W + GAP_CYC + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: accepts=%0d spacing=%0d required 2 accepts spacing %0d",
                     n_acc, acc_cyc[1] - acc_cyc[0], W + GAP_CYC + 1);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL b2b_drain: %0d bits left required 0", exp_q.size());
        end
        exp_q.delete();
        for (int c = 0; c < GAP_CYC + 4 && !in_ready; c++) @(negedge clk);
    endtask

    task automatic test_input_stability;
        bit e;
        @(negedge clk);
        in_data = 128'h1; in_valid = 1'b1; push_word(in_data);
        @(posedge clk); #1 in_valid = 1'b0; in_data = '1;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            e = exp_q.size() ? exp_q.pop_front() : 1'b0;
            n_checks++;
            if (out_clk_en !== 1'b1 || out_data !== e) begin
                n_fail++;
                $display("FAIL stable_bit %0d: en=%b data=%b required en=1 data=%b",
                         k, out_clk_en, out_data, e);
            end
        end
        in_data = '0;
        for (int c = 0; c < GAP_CYC + 4 && !in_ready; c++) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_clk_en !== 1'b0) begin
            n_fail++; $display("FAIL stable_end: ready=%b en=%b required 1 0", in_ready, out_clk_en);
        end
    endtask

    task automatic test_gap_length;
        bit e;
        int n;
        @(negedge clk);
        s_in_data = 8'hA5; s_in_valid = 1'b1; push_small(s_in_data);
        @(posedge clk); #1 s_in_valid = 1'b0;
        for (int k = 0; k < SW; k++) begin
            @(negedge clk);
            e = sexp_q.size() ? sexp_q.pop_front() : 1'b0;
            n_checks++;
            if (s_out_clk_en !== 1'b1 || s_out_data !== e || s_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_bit %0d: en=%b data=%b busy=%b required 1 %b 1",
                         k, s_out_clk_en, s_out_data, s_busy, e);
            end
        end
        @(negedge clk);
        n = 0;
        while (!s_in_ready && n < SGAP_CYC + 4) begin
            n_checks++;
            if ({s_out_data, s_out_clk_en, s_busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL gap_cycle %0d: data/en/busy=%b required 001",
                         n, {s_out_data, s_out_clk_en, s_busy});
            end
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != SGAP_CYC || s_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_len: ready after %0d cycles busy=%b required %0d cycles busy=0",
                     n, s_busy, SGAP_CYC);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [W-1:0] wa = {$urandom, $urandom, $urandom, $urandom};
        logic [W-1:0] wb = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
        bit e;
        @(negedge clk);
        in_data = wa; in_valid = 1'b1; push_word(wa);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k <= 50; k++) begin
            @(negedge clk);
            e = exp_q.size() ? exp_q.pop_front() : 1'b0;
            n_checks++;
            if (out_clk_en !== 1'b1 || out_data !== e) begin
                n_fail++;
                $display("FAIL abort_bit %0d: en=%b data=%b required en=1 data=%b",
                         k, out_clk_en, out_data, e);
            end
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_data, out_clk_en, busy, in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_reset: data/en/busy/ready=%b required 0001",
                     {out_data, out_clk_en, busy, in_ready});
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        in_data = wb; in_valid = 1'b1; push_word(wb);
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            e = exp_q.size() ? exp_q.pop_front() : 1'b0;
            n_checks++;
            if (out_clk_en !== 1'b1 || out_data !== e) begin
                n_fail++;
                $display("FAIL restart_bit %0d: en=%b data=%b required en=1 data=%b",
                         k, out_clk_en, out_data, e);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_clk_en !== 1'b0 || out_data !== 1'b0) begin
            n_fail++; $display("FAIL restart_end: en=%b data=%b required 0 0", out_clk_en, out_data);
        end
        for (int c = 0; c < GAP_CYC + 4 && !in_ready; c++) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_word();
        test_back_to_back();
        test_input_stability();
        test_gap_length();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_serializer.md
Name: sb_serializer

Overview:
- Sideband transmit-side serializer. Accepts a parallel WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clk, LSB first.
- Drives a clock-enable that gates the forwarded sideband clock, so the link-partner deserializer sees exactly WIDTH clock edges per word.
- Data changes on posedge clk so the receiver can sample on negedge clk.
- Sits between the sideband packet FIFO and the sideband TX pad.

Parameters:
- WIDTH, 128, bits per serialized word; must be ≥ 2.
- GAP, 32, idle cycles inserted after each word when the gap feature is compiled in; must be ≥ 1.
- WIDTH_W, $clog2(WIDTH), bit-counter width (derived).

Ports:
- clk  input  1  TX clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  WIDTH  parallel word to send; bit 0 is sent first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  serializer can accept a word this cycle.
- out_data  output  1  serial data to the pad; registered.
- out_clk_en  output  1  forwarded-clock enable; high exactly while a data bit is on out_data; registered.
- busy  output  1  state is not IDLE.

Behaviour:
- States are IDLE, SHIFT and GAP. Registers are state, shreg[WIDTH], bitcnt[WIDTH_W], gapcnt[$clog2(GAP+1)], out_data and out_clk_en.
- Reset (asynchronous, any state): state=IDLE, shreg=0, bitcnt=0, gapcnt=0, out_data=0, out_clk_en=0, busy=0, in_ready=1.
  - Reset mid-word aborts the word. The partial word is discarded and never resumed.
- in_ready = (state==IDLE), combinational from state only, with no dependence on in_valid.
- busy = (state!=IDLE).
- IDLE:
  - Accept when in_valid && in_ready at posedge E0.
  - On accept: shreg<=in_data>>1, out_data<=in_data[0], out_clk_en<=1, bitcnt<=0, state<=SHIFT.
  - in_data is sampled only at E0; later changes are ignored.
- SHIFT (one bit per posedge):
  - If bitcnt != WIDTH-1: out_data<=shreg[0], shreg<=shreg>>1, bitcnt<=bitcnt+1.
  - If bitcnt == WIDTH-1 (edge E_WIDTH): out_data<=0, out_clk_en<=0, bitcnt<=0, state<=GAP or IDLE (see Optional Feature).
- Timing: in_data[k] is on out_data with out_clk_en=1 from posedge E_k to E_{k+1}, for k = 0..WIDTH-1.
  - Exactly WIDTH consecutive enabled cycles per word.
  - Latency from accepting edge to first bit is 0 cycles; bit 0 is driven by the accept edge itself.
- GAP: out_data=0 and out_clk_en=0. gapcnt counts 0..GAP-1; at gapcnt==GAP-1, gapcnt<=0 and state<=IDLE.
- Back-to-back: the minimum spacing between the accept of word N and the accept of word N+1 is WIDTH+1 cycles without gap and WIDTH+GAP+1 cycles with gap. The single IDLE cycle is mandatory.
- in_valid is ignored outside IDLE; there is no buffering.
- Outside SHIFT, out_data is held at 0. out_clk_en is never high outside SHIFT.

Optional Feature:
- Macro: SB_SER_GAP_EN.
- Defined: SHIFT→GAP at E_WIDTH. The GAP state and gapcnt exist, and the line is held idle (data 0, clock gated) for GAP cycles before IDLE.
- Undefined: SHIFT→IDLE directly at E_WIDTH. The GAP state and gapcnt are not synthesized and the GAP parameter is unused.

Test Plan:
- Reset then single word: rst pulse, then in_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 with in_valid for 1 cycle -> out_data reproduces bits 0..127 LSB first on 128 consecutive cycles with out_clk_en=1; afterwards out_data=0 and out_clk_en=0; a negedge-sampling model rebuilds the same 128-bit value.
- Handshake hold-off: in_valid held high continuously with two words -> in_ready=0 throughout SHIFT/GAP; second accept occurs exactly 129 cycles after the first (no SB_SER_GAP_EN) or 161 cycles after (SB_SER_GAP_EN, GAP=32); the second word is serialized intact.
- Input stability: after accepting 128'h1, drive in_data=all-ones during SHIFT -> output is 1 followed by 127 zeros; the change is ignored.
- Gap length: with SB_SER_GAP_EN and GAP=4, WIDTH=8, send 8'hA5 -> bits 1,0,1,0,0,1,0,1 for 8 cycles, then 4 cycles with out_clk_en=0 and busy=1, then in_ready=1.
- Reset mid-word: assert rst asynchronously after bit 50 of a word -> out_clk_en, out_data and busy drop to 0 immediately, in_ready=1; the next word starts at bit 0 with no residue.
- No-valid idle: in_valid=0 for 200 cycles after reset -> out_clk_en stays 0, out_data stays 0, in_ready stays 1.
